// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_pkg
// Description : Shared types and constants for the rr_arbiter8 arbiter.
//               Holds the arbiter state enum, default parameter values, the
//               index-width constant and a helper that sizes the hold counter.
// Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

  localparam int ARB_N_DEFAULT        = 8;
  localparam int ARB_MAX_HOLD_DEFAULT = 16;
  localparam int ARB_IW               = $clog2(ARB_N_DEFAULT);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_e;

  // Hold counter width: log2(MAX_HOLD)+1, with a 1-bit floor so an
  // unlimited configuration (MAX_HOLD=0) still has a legal vector.
  function automatic int hold_cnt_width(input int max_hold);
    return (max_hold > 0) ? ($clog2(max_hold) + 1) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational winner selection for the arbiter.
//               Optionally masks one requester, then performs a two-pass
//               priority search: lowest request at or above ptr_i first, then
//               lowest request overall. In fixed mode the first pass covers
//               every index, so the lowest index simply wins.
// Ports       : req_i      - request vector
//               mask_idx_i - index of the requester to exclude
//               mask_en_i  - enables the exclusion
//               ptr_i      - round-robin start pointer
//               mode_i     - 0 fixed priority, 1 round-robin
//               win_oh_o   - one-hot winner
//               win_idx_o  - binary index of the winner
//               found_o    - a winner exists
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] mask_idx_i,
  input  logic          mask_en_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          mode_i,
  output logic [N-1:0]  win_oh_o,
  output logic [IW-1:0] win_idx_o,
  output logic          found_o
);

  logic [N-1:0] w_eff;
  logic [N-1:0] w_upper;
  logic [N-1:0] w_cand;

  always_comb begin
    w_eff = req_i;
    if (mask_en_i) begin
      w_eff[mask_idx_i] = 1'b0;
    end

    // First pass: requests at or above the pointer (all of them in fixed mode)
    w_upper = '0;
    for (int i = 0; i < N; i++) begin
      w_upper[i] = w_eff[i] && (!mode_i || (IW'(i) >= ptr_i));
    end

    // Second pass only when the first found nothing; this is the wrap-around
    w_cand = (|w_upper) ? w_upper : w_eff;

    // Descending scan so the lowest set index is the last one written
    win_idx_o = '0;
    found_o   = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_cand[i]) begin
        win_idx_o = IW'(i);
        found_o   = 1'b1;
      end
    end

    win_oh_o = '0;
    if (found_o) begin
      win_oh_o[win_idx_o] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter8.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter8
// Description : N-requester bus arbiter with registered, held one-hot grants.
//               Fixed or round-robin priority selected at run time; a hold
//               counter forcibly revokes a grant after MAX_HOLD cycles.
// Ports       : clk       - clock, rising edge active
//               rst_n     - asynchronous active-low reset
//               req       - request vector, held high while the resource is needed
//               mode      - 0 fixed priority, 1 round-robin
//               gnt       - one-hot grant (registered)
//               gnt_idx   - binary index of the granted requester (registered)
//               gnt_valid - any grant active
//               timeout   - one-cycle pulse after a forced revocation
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int N        = ARB_N_DEFAULT,
  parameter int MAX_HOLD = ARB_MAX_HOLD_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 mode,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_valid,
  output logic                 timeout
);

  localparam int IW  = $clog2(N);
  localparam int HCW = hold_cnt_width(MAX_HOLD);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);

  arb_state_e     state_q,   state_d;
  logic [N-1:0]   gnt_q,     gnt_d;
  logic [IW-1:0]  gnt_idx_q, gnt_idx_d;
  logic [IW-1:0]  ptr_q,     ptr_d;
  logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
  logic           timeout_q, timeout_d;

  logic [N-1:0]   w_win_oh;
  logic [IW-1:0]  w_win_idx;
  logic           w_found;
  logic           w_owner_req;
  logic           w_hold_lim;

  // While owned, the current owner is always excluded from arbitration;
  // it only keeps the resource through the normal-hold path.
  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req_i      (req),
    .mask_idx_i (gnt_idx_q),
    .mask_en_i  (state_q == OWNED),
    .ptr_i      (ptr_q),
    .mode_i     (mode),
    .win_oh_o   (w_win_oh),
    .win_idx_o  (w_win_idx),
    .found_o    (w_found)
  );

  assign w_owner_req = req[gnt_idx_q];
  assign w_hold_lim  = (MAX_HOLD > 0) && (hold_cnt_q == HOLD_LAST);

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_idx_d  = gnt_idx_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (w_found) begin
          state_d    = OWNED;
          gnt_d      = w_win_oh;
          gnt_idx_d  = w_win_idx;
          ptr_d      = w_win_idx + IW'(1);
          hold_cnt_d = '0;
        end
      end

      OWNED: begin
        if (w_owner_req && !w_hold_lim) begin
          // Normal hold; saturate so an unlimited hold never wraps
          if (hold_cnt_q != {HCW{1'b1}}) begin
            hold_cnt_d = hold_cnt_q + HCW'(1);
          end
        end else if (w_found) begin
          // Back-to-back handover, voluntary or forced
          gnt_d      = w_win_oh;
          gnt_idx_d  = w_win_idx;
          ptr_d      = w_win_idx + IW'(1);
          hold_cnt_d = '0;
          timeout_d  = w_owner_req;
        end else if (w_owner_req) begin
          // Forced release with nobody waiting: re-grant the same owner
          ptr_d      = gnt_idx_q + IW'(1);
          hold_cnt_d = '0;
          timeout_d  = 1'b1;
        end else begin
          state_d    = IDLE;
          gnt_d      = '0;
          gnt_idx_d  = '0;
          hold_cnt_d = '0;
        end
      end

      default: begin
        state_d   = IDLE;
        gnt_d     = '0;
        gnt_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      gnt_idx_q  <= '0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_idx_q  <= gnt_idx_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = |gnt_q;
  assign timeout   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter8.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_arbiter8
// Description : Self-checking bench for rr_arbiter8. Three instances with
//               MAX_HOLD = 16, 4 and 3 share one stimulus stream; each is
//               compared every cycle against its own behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter8;

  localparam int NDUT = 3;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       mode;

  logic [7:0] gnt0, gnt1, gnt2;
  logic [2:0] idx0, idx1, idx2;
  logic       vld0, vld1, vld2;
  logic       to0,  to1,  to2;

  int nvec;
  int nerr;

  rr_arbiter8 #(.N(8), .MAX_HOLD(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .req(req), .mode(mode),
    .gnt(gnt0), .gnt_idx(idx0), .gnt_valid(vld0), .timeout(to0));

  rr_arbiter8 #(.N(8), .MAX_HOLD(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req(req), .mode(mode),
    .gnt(gnt1), .gnt_idx(idx1), .gnt_valid(vld1), .timeout(to1));

  rr_arbiter8 #(.N(8), .MAX_HOLD(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req(req), .mode(mode),
    .gnt(gnt2), .gnt_idx(idx2), .gnt_valid(vld2), .timeout(to2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // owner = -1 when idle; held = cycles the current grant has been visible
  typedef struct {
    int owner;
    int held;
    int ptr;
    bit to;
  } mst_t;

  mst_t ms [NDUT];
  int   mh [NDUT] = '{16, 4, 3};

  function automatic mst_t mreset();
    mst_t s;
    s.owner = -1; s.held = 0; s.ptr = 0; s.to = 1'b0;
    return s;
  endfunction

  function automatic mst_t mstep(mst_t s, logic [7:0] r, logic m, int lim);
    mst_t n;
    int   w;
    bit   forced;
    n    = s;
    n.to = 1'b0;
    if (s.owner >= 0 && r[s.owner] && !(lim > 0 && s.held == lim)) begin
      n.held = s.held + 1;
      return n;
    end
    forced = (s.owner >= 0) && r[s.owner];
    w = -1;
    for (int j = 0; j < 8; j++) begin
      int c;
      c = m ? ((s.ptr + j) % 8) : j;
      if (w < 0 && r[c] && c != s.owner) w = c;
    end
    if (w >= 0) begin
      n.owner = w; n.held = 1; n.ptr = (w + 1) % 8; n.to = forced;
    end else if (forced) begin
      n.held = 1; n.ptr = (s.owner + 1) % 8; n.to = 1'b1;
    end else begin
      n.owner = -1; n.held = 0;
    end
    return n;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", name, k, $time, act, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NDUT; k++) begin
      logic [7:0] g, egnt;
      logic [2:0] ix;
      logic       v, t;
      case (k)
        0:       begin g = gnt0; ix = idx0; v = vld0; t = to0; end
        1:       begin g = gnt1; ix = idx1; v = vld1; t = to1; end
        default: begin g = gnt2; ix = idx2; v = vld2; t = to2; end
      endcase
      egnt = (ms[k].owner >= 0) ? (8'h01 << ms[k].owner) : 8'h00;
      chk("gnt", k, g, egnt);
      chk("gnt_valid", k, {7'b0, v}, {7'b0, ms[k].owner >= 0});
      chk("timeout", k, {7'b0, t}, {7'b0, ms[k].to});
      if (ms[k].owner >= 0) chk("gnt_idx", k, {5'b0, ix}, 8'(ms[k].owner));
    end
  endtask

  // Drive inputs, advance one rising edge, then compare at the falling edge
  task automatic cyc(input logic [7:0] r, input logic m);
    req  = r;
    mode = m;
    @(posedge clk);
    for (int k = 0; k < NDUT; k++) ms[k] = mstep(ms[k], r, m, mh[k]);
    @(negedge clk);
    check_all();
  endtask

  task automatic check_zero(input string name);
    chk({name, "_gnt0"}, 0, gnt0, 8'h00);
    chk({name, "_gnt1"}, 1, gnt1, 8'h00);
    chk({name, "_gnt2"}, 2, gnt2, 8'h00);
    chk({name, "_misc"}, 0, {vld0, vld1, vld2, to0, to1, to2, 2'b00}, 8'h00);
    chk({name, "_idx"},  0, {2'b00, idx0, idx1}, 8'h00);
  endtask

  // ---------------- directed table (checked against MAX_HOLD=16 instance) ----------------
  typedef struct {
    logic [7:0] req;
    logic       mode;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       vld;
  } vec_t;

  vec_t tbl [11];

  initial begin
    logic [7:0] r;
    logic       m;

    nvec = 0; nerr = 0;
    rst_n = 1'b0; req = 8'h00; mode = 1'b0;
    for (int k = 0; k < NDUT; k++) ms[k] = mreset();

    tbl[0]  = '{8'hA4, 1'b0, 8'h04, 3'd2, 1'b1};
    tbl[1]  = '{8'hA4, 1'b0, 8'h04, 3'd2, 1'b1};
    tbl[2]  = '{8'hA0, 1'b0, 8'h20, 3'd5, 1'b1}; // back-to-back, no bubble
    tbl[3]  = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0};
    tbl[4]  = '{8'h81, 1'b1, 8'h80, 3'd7, 1'b1}; // ptr=6 -> 7 wins
    tbl[5]  = '{8'h01, 1'b1, 8'h01, 3'd0, 1'b1}; // ptr wrapped to 0
    tbl[6]  = '{8'h03, 1'b1, 8'h01, 3'd0, 1'b1};
    tbl[7]  = '{8'h02, 1'b0, 8'h02, 3'd1, 1'b1};
    tbl[8]  = '{8'h06, 1'b1, 8'h02, 3'd1, 1'b1}; // mode change while held
    tbl[9]  = '{8'h05, 1'b1, 8'h04, 3'd2, 1'b1}; // round-robin now in effect
    tbl[10] = '{8'h00, 1'b1, 8'h00, 3'd0, 1'b0};

    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("post_reset");

    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].req, tbl[i].mode);
      chk("tbl_gnt", 0, gnt0, tbl[i].gnt);
      chk("tbl_vld", 0, {7'b0, vld0}, {7'b0, tbl[i].vld});
      if (tbl[i].vld) chk("tbl_idx", 0, {5'b0, idx0}, {5'b0, tbl[i].idx});
    end

    // Round-robin all requesting: rotation with forced handovers
    repeat (40) cyc(8'hFF, 1'b1);
    cyc(8'h00, 1'b1);

    // Fixed mode, lone requester 5: repeated timeouts, grant never drops
    repeat (14) cyc(8'h20, 1'b0);
    chk("lone_vld3", 2, {7'b0, vld2}, 8'h01);
    cyc(8'h00, 1'b0);

    // Asynchronous reset in the middle of a grant to requester 4
    cyc(8'h10, 1'b0);
    chk("pre_rst_gnt", 0, gnt0, 8'h10);
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    for (int k = 0; k < NDUT; k++) ms[k] = mreset();
    @(negedge clk);
    check_zero("rst_held");
    rst_n = 1'b1;
    cyc(8'h10, 1'b0);
    chk("rst_regrant", 0, gnt0, 8'h10);
    cyc(8'h00, 1'b0);

    // Randomised traffic: persistent requests with occasional toggles
    r = 8'h00; m = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) r = 8'($urandom);
      else if ($urandom_range(0, 2) == 0) r[$urandom_range(0, 7)] ^= 1'b1;
      if ($urandom_range(0, 15) == 0) m = ~m;
      cyc(r, m);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
`default_nettype wire
